// File: rtl/if_id_skid_reg.sv
// IF/ID stage register with valid/ready handshake and a two-entry skid buffer.
// Also provides flush, NOP injection on empty, occupancy and a saturating stall counter.
module if_id_skid_reg #(
   parameter int                 ADDR_W    = 32,
   parameter int                 INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ADDR_W-1:0]  in_addr,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_addr,
   output logic [INSTR_W-1:0] out_instr,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    mainAddr_q, mainAddr_d;
   logic [INSTR_W-1:0]   mainInstr_q, mainInstr_d;
   logic [ADDR_W-1:0]    skidAddr_q, skidAddr_d;
   logic [INSTR_W-1:0]   skidInstr_q, skidInstr_d;
   logic [1:0]           occupancy_q, occupancy_d;
   logic [CNT_W-1:0]     stallCnt_q, stallCnt_d;

   logic mainValid;
   logic skidValid;
   logic accept;
   logic drain;

   // Valid bits come straight from the state, so in_ready never depends on out_ready.
   assign mainValid = (state_q != EMPTY);
   assign skidValid = (state_q == FULL);

   assign in_ready  = !skidValid;
   assign out_valid = mainValid;
   assign out_addr  = mainAddr_q;
   assign out_instr = mainInstr_q;
   assign occupancy = occupancy_q;
   assign stall_cnt = stallCnt_q;

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      mainAddr_d  = mainAddr_q;
      mainInstr_d = mainInstr_q;
      skidAddr_d  = skidAddr_q;
      skidInstr_d = skidInstr_q;

      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               mainAddr_d  = in_addr;
               mainInstr_d = in_instr;
               state_d     = ONE;
            end
         end
         ONE: begin
            if (accept && drain) begin
               mainAddr_d  = in_addr;
               mainInstr_d = in_instr;
            end else if (accept) begin
               skidAddr_d  = in_addr;
               skidInstr_d = in_instr;
               state_d     = FULL;
            end else if (drain) begin
               mainAddr_d  = '0;
               mainInstr_d = NOP_INSTR;
               state_d     = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               mainAddr_d  = skidAddr_q;
               mainInstr_d = skidInstr_q;
               skidAddr_d  = '0;
               skidInstr_d = NOP_INSTR;
               state_d     = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      // Flush discards both held entries and anything accepted this cycle.
      if (flush) begin
         state_d     = EMPTY;
         mainAddr_d  = '0;
         mainInstr_d = NOP_INSTR;
         skidAddr_d  = '0;
         skidInstr_d = NOP_INSTR;
      end
   end

   always_comb begin
      occupancy_d = 2'd0;
      unique case (state_d)
         ONE:     occupancy_d = 2'd1;
         FULL:    occupancy_d = 2'd2;
         default: occupancy_d = 2'd0;
      endcase
   end

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (out_valid && !out_ready && (stallCnt_q != CNT_MAX)) begin
         stallCnt_d = stallCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= EMPTY;
         mainAddr_q  <= '0;
         mainInstr_q <= NOP_INSTR;
         skidAddr_q  <= '0;
         skidInstr_q <= NOP_INSTR;
         occupancy_q <= 2'd0;
         stallCnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mainAddr_q  <= mainAddr_d;
         mainInstr_q <= mainInstr_d;
         skidAddr_q  <= skidAddr_d;
         skidInstr_q <= skidInstr_d;
         occupancy_q <= occupancy_d;
         stallCnt_q  <= stallCnt_d;
      end
   end

endmodule
